// File: rtl/traffic_light_array.sv
// traffic_light_array: a bank of NUM_LIGHTS red/green sequencers driven by one
// global IDLE/RUN/PAUSE controller and a shared tick enable.
// Per-light red/green durations and start colours are written over a single
// config port while idle. Optional feature macro: TRAFFIC_YELLOW_EN (adds a
// yellow phase of max(YELLOW_T,1) ticks after every green phase).
module traffic_light_array #(
  parameter int NUM_LIGHTS = 4,
  parameter int SEL_W      = 2,
  parameter int TIME_W     = 5,
  parameter int DEFAULT_T  = 5,
  parameter int YELLOW_T   = 2
) (
  input  logic                         clk,
  input  logic                         arst_i,
  input  logic                         tick_i,
  input  logic                         start_i,
  input  logic                         pause_i,
  input  logic                         stop_i,
  input  logic                         cfg_we_i,
  input  logic [SEL_W-1:0]             cfg_sel_i,
  input  logic                         cfg_color_i,
  input  logic                         cfg_start_i,
  input  logic [TIME_W-1:0]            cfg_time_i,
  output logic                         cfg_err_o,
  output logic [1:0]                   state_o,
  output logic [2*NUM_LIGHTS-1:0]      color_o,
  output logic [TIME_W*NUM_LIGHTS-1:0] remain_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam logic [1:0] C_RED = 2'b00;
  localparam logic [1:0] C_GRN = 2'b01;
`ifdef TRAFFIC_YELLOW_EN
  localparam logic [1:0] C_YEL = 2'b10;
  localparam logic [TIME_W-1:0] YEL_LOAD =
    (YELLOW_T < 1) ? TIME_W'(1) : TIME_W'(YELLOW_T);
`endif

  // Reject parameter sets the select port or channel count cannot support.
  if (NUM_LIGHTS < 1 || NUM_LIGHTS > 16 || (1 << SEL_W) < NUM_LIGHTS || YELLOW_T < 0)
  begin : g_param_check
    $error("traffic_light_array: invalid parameter combination");
  end

  state_e            state_q, state_d;
  logic              cfg_err_q, cfg_err_d;
  logic [TIME_W-1:0] red_t_q  [NUM_LIGHTS];
  logic [TIME_W-1:0] red_t_d  [NUM_LIGHTS];
  logic [TIME_W-1:0] grn_t_q  [NUM_LIGHTS];
  logic [TIME_W-1:0] grn_t_d  [NUM_LIGHTS];
  logic              start_q  [NUM_LIGHTS];
  logic              start_d  [NUM_LIGHTS];
  logic [1:0]        color_q  [NUM_LIGHTS];
  logic [1:0]        color_d  [NUM_LIGHTS];
  logic [TIME_W-1:0] remain_q [NUM_LIGHTS];
  logic [TIME_W-1:0] remain_d [NUM_LIGHTS];
  logic              wr_ok;
  logic              advance;

  // A zero duration behaves as one tick, so countdowns never show 0 once loaded.
  function automatic logic [TIME_W-1:0] eff_t(input logic [TIME_W-1:0] t);
    return (t == '0) ? TIME_W'(1) : t;
  endfunction

  // Global controller: stop beats start beats pause.
  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_i)            state_d = ST_RUN;
        ST_RUN:   if (pause_i)            state_d = ST_PAUSE;
        ST_PAUSE: if (start_i || pause_i) state_d = ST_RUN;
        default:                          state_d = ST_IDLE;
      endcase
    end
  end

  // Config write qualification and error pulse; ticks count only while staying in RUN.
  always_comb begin
    wr_ok     = cfg_we_i && (state_q == ST_IDLE) && (int'(cfg_sel_i) < NUM_LIGHTS);
    cfg_err_d = cfg_we_i && !wr_ok;
    advance   = tick_i && (state_q == ST_RUN) && (state_d == ST_RUN);
  end

  // Per-light storage update and colour/countdown sequencing.
  // IDLE display and the IDLE->RUN load share one path: both show the start
  // colour and its (post-write) duration, so the load is just the last display.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
      red_t_d[i]  = red_t_q[i];
      grn_t_d[i]  = grn_t_q[i];
      start_d[i]  = start_q[i];
      color_d[i]  = color_q[i];
      remain_d[i] = remain_q[i];

      if (wr_ok && (cfg_sel_i == SEL_W'(i))) begin
        if (cfg_color_i) grn_t_d[i] = cfg_time_i;
        else             red_t_d[i] = cfg_time_i;
        start_d[i] = cfg_start_i;
      end

      if (state_q == ST_IDLE || state_d == ST_IDLE) begin
        color_d[i]  = start_d[i] ? C_GRN : C_RED;
        remain_d[i] = eff_t(start_d[i] ? grn_t_d[i] : red_t_d[i]);
      end else if (advance) begin
        if (remain_q[i] > TIME_W'(1)) begin
          remain_d[i] = remain_q[i] - TIME_W'(1);
        end else begin
          case (color_q[i])
            C_RED: begin
              color_d[i]  = C_GRN;
              remain_d[i] = eff_t(grn_t_q[i]);
            end
`ifdef TRAFFIC_YELLOW_EN
            C_GRN: begin
              color_d[i]  = C_YEL;
              remain_d[i] = YEL_LOAD;
            end
`endif
            default: begin
              color_d[i]  = C_RED;
              remain_d[i] = eff_t(red_t_q[i]);
            end
          endcase
        end
      end
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_IDLE;
      cfg_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
        red_t_q[i]  <= TIME_W'(DEFAULT_T);
        grn_t_q[i]  <= TIME_W'(DEFAULT_T);
        start_q[i]  <= 1'b0;
        color_q[i]  <= C_RED;
        remain_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
        red_t_q[i]  <= red_t_d[i];
        grn_t_q[i]  <= grn_t_d[i];
        start_q[i]  <= start_d[i];
        color_q[i]  <= color_d[i];
        remain_q[i] <= remain_d[i];
      end
    end
  end

  // Flatten per-light registers onto the packed output buses.
  always_comb begin
    color_o  = '0;
    remain_o = '0;
    for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
      color_o[2*i +: 2]           = color_q[i];
      remain_o[TIME_W*i +: TIME_W] = remain_q[i];
    end
  end

  assign state_o   = state_q;
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_traffic_light_array.sv
// Testbench for traffic_light_array: directed table, corner sequences and
// randomized traffic against a tick-count reference model.
module tb_traffic_light_array;

  localparam int NL = 4;
  localparam int TW = 5;
  localparam int YT = 2;

  logic            clk = 1'b0;
  logic            arst_i;
  logic            tick_i, start_i, pause_i, stop_i;
  logic            cfg_we_i, cfg_color_i, cfg_start_i;
  logic [2:0]      cfg_sel_i;
  logic [TW-1:0]   cfg_time_i;
  logic            cfg_err_o;
  logic [1:0]      state_o;
  logic [2*NL-1:0] color_o;
  logic [TW*NL-1:0] remain_o;

  traffic_light_array #(
    .NUM_LIGHTS(NL), .SEL_W(3), .TIME_W(TW), .DEFAULT_T(5), .YELLOW_T(YT)
  ) dut (
    .clk(clk), .arst_i(arst_i), .tick_i(tick_i), .start_i(start_i),
    .pause_i(pause_i), .stop_i(stop_i), .cfg_we_i(cfg_we_i),
    .cfg_sel_i(cfg_sel_i), .cfg_color_i(cfg_color_i),
    .cfg_start_i(cfg_start_i), .cfg_time_i(cfg_time_i),
    .cfg_err_o(cfg_err_o), .state_o(state_o), .color_o(color_o),
    .remain_o(remain_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Durations and start colours per light, global mode, and the number of
  // ticks counted since the last load; each light's colour is found by
  // locating that count inside its repeating colour cycle.
  int m_red [NL];
  int m_grn [NL];
  int m_st  [NL];
  int m_state;
  int m_k;
  int m_err;

  function automatic int eff(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_red[i] = 5; m_grn[i] = 5; m_st[i] = 0;
    end
    m_state = 0; m_k = 0; m_err = 0;
  endfunction

  task automatic exp_light(input int i, output int col, output int rem);
    int cols [3];
    int durs [3];
    int n, per, o;
    if (m_state == 0) begin
      col = m_st[i];
      rem = eff(m_st[i] != 0 ? m_grn[i] : m_red[i]);
    end else begin
`ifdef TRAFFIC_YELLOW_EN
      n = 3;
      if (m_st[i] != 0) begin
        cols = '{1, 2, 0}; durs = '{eff(m_grn[i]), eff(YT), eff(m_red[i])};
      end else begin
        cols = '{0, 1, 2}; durs = '{eff(m_red[i]), eff(m_grn[i]), eff(YT)};
      end
`else
      n = 2;
      if (m_st[i] != 0) begin
        cols = '{1, 0, 0}; durs = '{eff(m_grn[i]), eff(m_red[i]), 0};
      end else begin
        cols = '{0, 1, 0}; durs = '{eff(m_red[i]), eff(m_grn[i]), 0};
      end
`endif
      per = 0;
      for (int s = 0; s < n; s++) per += durs[s];
      o = m_k % per;
      col = 0; rem = 0;
      for (int s = 0; s < n; s++) begin
        if (o < durs[s]) begin
          col = cols[s]; rem = durs[s] - o;
          break;
        end
        o -= durs[s];
      end
    end
  endtask

  function automatic void model_step();
    int cur = m_state;
    bit acc = cfg_we_i && (cur == 0) && (cfg_sel_i < 3'(NL));
    m_err = (cfg_we_i && !acc) ? 1 : 0;
    if (acc) begin
      if (cfg_color_i) m_grn[cfg_sel_i] = int'(cfg_time_i);
      else             m_red[cfg_sel_i] = int'(cfg_time_i);
      m_st[cfg_sel_i] = int'(cfg_start_i);
    end
    if (stop_i) m_state = 0;
    else if (cur == 0) begin
      if (start_i) begin m_state = 1; m_k = 0; end
    end else if (cur == 1) begin
      if (pause_i) m_state = 2;
      else if (tick_i) m_k++;
    end else if (start_i || pause_i) m_state = 1;
  endfunction

  // Apply one cycle of inputs, advance the model, compare at the falling edge.
  task automatic step(input logic st, pa, sp, tk, we, input logic [2:0] sl,
                      input logic cc, cs, input logic [TW-1:0] t);
    logic [2*NL-1:0]  ecol;
    logic [TW*NL-1:0] erem;
    int c, r;
    start_i = st; pause_i = pa; stop_i = sp; tick_i = tk; cfg_we_i = we;
    cfg_sel_i = sl; cfg_color_i = cc; cfg_start_i = cs; cfg_time_i = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    ecol = '0; erem = '0;
    for (int i = 0; i < NL; i++) begin
      exp_light(i, c, r);
      ecol[2*i +: 2]   = 2'(c);
      erem[TW*i +: TW] = TW'(r);
    end
    chk("state",   32'(state_o),   32'(m_state));
    chk("cfg_err", 32'(cfg_err_o), 32'(m_err));
    chk("color",   32'(color_o),   32'(ecol));
    chk("remain",  32'(remain_o),  32'(erem));
  endtask

  task automatic idle_cyc();  step(0,0,0,0,0,3'd0,0,0,5'd0); endtask
  task automatic tick_cyc();  step(0,0,0,1,0,3'd0,0,0,5'd0); endtask
  task automatic start_cyc(); step(1,0,0,0,0,3'd0,0,0,5'd0); endtask
  task automatic pause_cyc(); step(0,1,0,0,0,3'd0,0,0,5'd0); endtask
  task automatic stop_cyc();  step(0,0,1,0,0,3'd0,0,0,5'd0); endtask
  task automatic wr_cyc(input int sl, input int cc, input int cs, input int t);
    step(0,0,0,0,1,3'(sl),1'(cc),1'(cs),5'(t));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic st, pa, sp, tk, we;
    logic [2:0] sel;
    logic cc, cs;
    logic [TW-1:0] t;
    logic [1:0] e_state;
    logic e_err;
    logic [7:0] e_col;
    logic [19:0] e_rem;
  } vec_t;

  function automatic logic [19:0] rem4(input int a, b, c, d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction
  function automatic logic [7:0] col4(input int a, b, c, d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction
  function automatic vec_t mk(input int st, pa, sp, tk, we, sl, cc, cs, t,
                              input int es, ee, input logic [7:0] ec, input logic [19:0] er);
    vec_t v;
    v.st = 1'(st); v.pa = 1'(pa); v.sp = 1'(sp); v.tk = 1'(tk); v.we = 1'(we);
    v.sel = 3'(sl); v.cc = 1'(cc); v.cs = 1'(cs); v.t = 5'(t);
    v.e_state = 2'(es); v.e_err = 1'(ee); v.e_col = ec; v.e_rem = er;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    arst_i = 1'b1;
    tick_i = 0; start_i = 0; pause_i = 0; stop_i = 0;
    cfg_we_i = 0; cfg_sel_i = '0; cfg_color_i = 0; cfg_start_i = 0; cfg_time_i = '0;

    //            st pa sp tk we sl cc cs t   state err colour            remain
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, col4(0,0,0,0), rem4(5,5,5,5));
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, col4(0,0,0,0), rem4(5,5,5,5));
    tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, col4(0,0,0,0), rem4(4,4,4,4));
    tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, col4(0,0,0,0), rem4(3,3,3,3));
    tbl[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, col4(0,0,0,0), rem4(2,2,2,2));
    tbl[5]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, col4(0,0,0,0), rem4(1,1,1,1));
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, col4(1,1,1,1), rem4(5,5,5,5));
    tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, col4(0,0,0,0), rem4(5,5,5,5));
    tbl[8]  = mk(0, 0, 0, 0, 1, 2, 1, 1, 3,  0, 0, col4(0,0,1,0), rem4(5,5,3,5));
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, col4(0,0,1,0), rem4(5,5,3,5));
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, col4(0,0,1,0), rem4(4,4,2,4));
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, col4(0,0,1,0), rem4(3,3,1,3));
`ifdef TRAFFIC_YELLOW_EN
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, col4(0,0,2,0), rem4(2,2,2,2));
    tbl[13] = mk(0, 0, 0, 0, 1, 1, 0, 0, 9,  1, 1, col4(0,0,2,0), rem4(2,2,2,2));
`else
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, col4(0,0,0,0), rem4(2,2,5,2));
    tbl[13] = mk(0, 0, 0, 0, 1, 1, 0, 0, 9,  1, 1, col4(0,0,0,0), rem4(2,2,5,2));
`endif
    tbl[14] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, col4(0,0,1,0), rem4(5,5,3,5));
    tbl[15] = mk(0, 0, 0, 0, 1, 5, 0, 0, 1,  0, 1, col4(0,0,1,0), rem4(5,5,3,5));
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, col4(0,0,1,0), rem4(5,5,3,5));

    // Reset state while arst_i is held.
    repeat (2) @(negedge clk);
    chk("rst_state",  32'(state_o),   32'd0);
    chk("rst_color",  32'(color_o),   32'd0);
    chk("rst_remain", 32'(remain_o),  32'd0);
    chk("rst_err",    32'(cfg_err_o), 32'd0);
    arst_i = 1'b0;
    model_reset();

    for (int n = 0; n < 17; n++) begin
      step(tbl[n].st, tbl[n].pa, tbl[n].sp, tbl[n].tk, tbl[n].we,
           tbl[n].sel, tbl[n].cc, tbl[n].cs, tbl[n].t);
      chk($sformatf("tbl%0d_state", n),  32'(state_o),   32'(tbl[n].e_state));
      chk($sformatf("tbl%0d_err", n),    32'(cfg_err_o), 32'(tbl[n].e_err));
      chk($sformatf("tbl%0d_color", n),  32'(color_o),   32'(tbl[n].e_col));
      chk($sformatf("tbl%0d_remain", n), 32'(remain_o),  32'(tbl[n].e_rem));
    end

    // Pause freezes the countdown and resume continues it.
    start_cyc();
    tick_cyc();
    chk("pre_pause_remain", 32'(remain_o[4:0]), 32'd4);
    pause_cyc();
    repeat (10) tick_cyc();
    chk("pause_state",  32'(state_o), 32'd2);
    chk("pause_remain", 32'(remain_o[4:0]), 32'd4);
    pause_cyc();
    chk("resume_remain", 32'(remain_o[4:0]), 32'd4);
    tick_cyc();
    chk("resume_tick_remain", 32'(remain_o[4:0]), 32'd3);

    // stop and start together: stop wins.
    step(1,0,1,0,0,3'd0,0,0,5'd0);
    chk("stop_start_state", 32'(state_o), 32'd0);

    // Zero red duration lasts exactly one tick.
    wr_cyc(0, 0, 0, 0);
    start_cyc();
    chk("zero_red_color",  32'(color_o[1:0]),  32'd0);
    chk("zero_red_remain", 32'(remain_o[4:0]), 32'd1);
    tick_cyc();
    chk("zero_red_next_color",  32'(color_o[1:0]),  32'd1);
    chk("zero_red_next_remain", 32'(remain_o[4:0]), 32'd5);
    stop_cyc();

    // A tick coinciding with start is not counted.
    step(1,0,0,1,0,3'd0,0,0,5'd0);
    chk("start_tick_remain", 32'(remain_o[9:5]), 32'd5);
    stop_cyc();

`ifdef TRAFFIC_YELLOW_EN
    // Green 3 ticks, yellow 2 ticks, then red.
    wr_cyc(3, 1, 1, 3);
    start_cyc();
    repeat (3) tick_cyc();
    chk("yel_color",  32'(color_o[7:6]),   32'd2);
    chk("yel_remain", 32'(remain_o[19:15]), 32'd2);
    tick_cyc();
    chk("yel_color2", 32'(color_o[7:6]), 32'd2);
    tick_cyc();
    chk("yel_to_red", 32'(color_o[7:6]), 32'd0);
    stop_cyc();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(0, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
